// File: rtl/seq_det_ctrl.sv
// Serial pattern detector driving a load/run/clear datapath sequencer.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for an accepted detection
//   LOAD  | one-cycle datapath load pulse, run timer armed
//   RUN   | datapath enabled until status or timer terminal count
//   CLEAR | one-cycle datapath clear pulse, then back to IDLE
module seq_det_ctrl #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
    parameter int               TMO_W   = 8,
    parameter int               TIMEOUT = 100,
    parameter int               MISS_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              d_in,
    input  logic              status,
    input  logic              err_clr,
    output logic              q_out,
    output logic              ld,
    output logic              en,
    output logic              clr,
    output logic              busy,
    output logic              err,
    output logic [MISS_W-1:0] miss
);

    localparam int                FILL_W   = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
    // Run timer counts down from TIMEOUT-1; terminal count is zero.
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [PAT_W-2:0]   hist;
    logic [FILL_W-1:0]  fill;
    logic [PAT_W-1:0]   window;
    logic               primed;
    logic [TMO_W-1:0]   timer;
    logic               tmo_tc;
    logic               abort;

    assign window = {hist, d_in};
    assign primed = (fill == FILL_MAX);
    assign q_out  = primed && (window == PATTERN);
    assign tmo_tc = (timer == '0);
    // A status in the terminal cycle wins over the timeout.
    assign abort  = (state == RUN) && !status && tmo_tc;

    // Detector history and fill count; independent of the sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= window[PAT_W-2:0];
            if (fill != FILL_MAX) begin
                fill <= fill + 1'b1;
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and datapath controls decoded from the current state.
    always_comb begin
        state_nxt = state;
        ld        = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (q_out) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                ld        = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                en = 1'b1;
                if (status || tmo_tc) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                clr       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Run timer: armed in LOAD, counts down while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (state == LOAD) begin
            timer <= TMO_LAST;
        end else if (state == RUN && !tmo_tc) begin
            timer <= timer - 1'b1;
        end
    end

    // Sticky abort flag; a new abort beats a simultaneous clear request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (abort) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

    // Saturating count of detections that arrive while the sequencer is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss <= '0;
        end else if (q_out && state != IDLE && miss != '1) begin
            miss <= miss + 1'b1;
        end
    end

endmodule
